// File: rtl/sr_arb_pkg.sv
// sr_arb_pkg
//   Shared types for the sr_mem_arbiter slice: the arbiter FSM state
//   encoding and the transaction-owner encoding.
//   No ports.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/sr_arb_pick.sv
// sr_arb_pick
//   Combinational winner select between the fetch and data requesters.
//   Only meaningful when at least one request is high.
//   Build option: SR_ARB_ROUND_ROBIN_EN
//     undefined - fixed priority, data port wins a tie
//     defined   - on a tie the requester not granted last wins
// Ports
//   ifReq     in   fetch request
//   dmReq     in   data request
//   lastOwner in   owner of the most recent grant (1 = data port)
//   winnerDm  out  1 = data port wins, 0 = fetch port wins
module sr_arb_pick
    import sr_arb_pkg::*;
(
    input  logic ifReq,
    input  logic dmReq,
    input  logic lastOwner,
    output logic winnerDm
);

`ifdef SR_ARB_ROUND_ROBIN_EN
    // Tie goes to whichever side was not served last.
    assign winnerDm = (ifReq && dmReq) ? (lastOwner == OWN_IF) : dmReq;
`else
    // Data port has priority, so a single dmReq decides everything.
    logic unusedPickInputs;
    assign unusedPickInputs = ifReq ^ lastOwner;
    assign winnerDm = dmReq;
`endif

endmodule

// File: rtl/sr_mem_arbiter.sv
// sr_mem_arbiter
//   Shares one single-port memory between the CPU fetch port and data port.
//   One transaction in flight: the winner is latched in IDLE, presented to
//   memory with a req/ready handshake in ISSUE, and for reads the response
//   is routed back to the owner in WAIT.
//   Build option: SR_ARB_ROUND_ROBIN_EN (tie policy, see sr_arb_pick).
// Ports
//   clk, rst                       clock, async active-high reset
//   if_req/if_addr                 fetch read request
//   if_gnt/if_rvalid/if_rdata      fetch accept pulse, response pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata  data request
//   dm_gnt/dm_rvalid/dm_rdata      data accept pulse, read response, data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_ready/mem_rvalid/mem_rdata     memory accept and read response
//   busy                           FSM not in IDLE
module sr_mem_arbiter
    import sr_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t lastOwner;
    logic       pickDm;
    logic       accept;

    sr_arb_pick uPick (
        .ifReq     (if_req),
        .dmReq     (dm_req),
        .lastOwner (lastOwner),
        .winnerDm  (pickDm)
    );

    // Grant must coincide with the memory accepting, so it is decoded from
    // the registered state rather than registered itself.
    assign accept = (state == ARB_ISSUE) && mem_ready;
    assign if_gnt = accept && (owner == OWN_IF);
    assign dm_gnt = accept && (owner == OWN_DM);
    assign busy   = (state != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            lastOwner <= OWN_DM;      // first round-robin tie goes to fetch
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (if_req || dm_req) begin
                        owner     <= arb_owner_t'(pickDm);
                        mem_req   <= 1'b1;
                        mem_we    <= pickDm & dm_we;
                        mem_addr  <= pickDm ? dm_addr : if_addr;
                        mem_wdata <= pickDm ? dm_wdata : '0;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        lastOwner <= owner;
                        // Writes have no response phase.
                        state     <= mem_we ? ARB_IDLE : ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_DM) begin
                            dm_rvalid <= 1'b1;
                            dm_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_mem_arbiter.sv
module tb_sr_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    sr_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rvalidCount = 0;
    int gntCount = 0;
    int lastRvalidCyc = -1;
    logic [31:0] lastIfData = '0;
    logic [31:0] lastDmData = '0;

    typedef struct packed {
        logic        dm;
        logic [31:0] data;
    } exp_t;
    exp_t expQ[$];
    exp_t expHead;

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: every rvalid must match the oldest expectation.
    always @(negedge clk) begin
        if (if_gnt || dm_gnt) gntCount++;
        if (if_rvalid && dm_rvalid) begin
            total++; bad++;
            $display("FAIL rvalid_both: if_rvalid=1 dm_rvalid=1, required at most one");
        end
        if (if_rvalid || dm_rvalid) begin
            rvalidCount++;
            lastRvalidCyc = cyc;
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b dm_rvalid=%0b, required none", if_rvalid, dm_rvalid);
            end else begin
                expHead = expQ.pop_front();
                if (dm_rvalid !== expHead.dm || (dm_rvalid ? dm_rdata : if_rdata) !== expHead.data) begin
                    bad++;
                    $display("FAIL rvalid_data: owner_dm=%0b data=%h, required owner_dm=%0b data=%h",
                             dm_rvalid, dm_rvalid ? dm_rdata : if_rdata, expHead.dm, expHead.data);
                end
            end
        end
    end

    task automatic push_exp(input logic dm, input logic [31:0] data);
        exp_t e;
        e.dm = dm;
        e.data = data;
        expQ.push_back(e);
        if (dm) lastDmData = data; else lastIfData = data;
    endtask

    // Memory responder: waits for mem_req, stalls readyLow cycles, accepts,
    // then for reads returns rdata rvalLag cycles after the accept cycle.
    task automatic mem_serve(input int readyLow, input int rvalLag, input logic [31:0] rdata,
                             output logic sawIf, output logic sawDm);
        int w;
        logic isWrite;
        w = 0;
        sawIf = 1'b0;
        sawDm = 1'b0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (mem_req !== 1'b1) begin
            total++; bad++;
            $display("FAIL mem_req_timeout: mem_req=%b after %0d cycles, required 1", mem_req, w);
            return;
        end
        repeat (readyLow) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        sawIf = if_gnt;
        sawDm = dm_gnt;
        isWrite = mem_we;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (!isWrite) begin
            repeat (rvalLag - 1) begin
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b we=%b busy=%b addr=%h wdata=%h ifr=%h dmr=%h, required all 0",
                     mem_req, mem_we, busy, mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b mem_req=%b, required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_fetch;
        int n;
        logic si, sd;
        if_req = 1; if_addr = 32'h40;
        n = cyc;
        push_exp(1'b0, 32'h00500093);
        @(posedge clk); #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b, required 1 00000040 0", mem_req, mem_addr, mem_we);
        end
        mem_serve(0, 1, 32'h00500093, si, sd);
        if_req = 0;
        total++;
        if (si !== 1'b1 || sd !== 1'b0) begin
            bad++;
            $display("FAIL fetch_gnt: if_gnt=%b dm_gnt=%b, required 1 0", si, sd);
        end
        @(posedge clk); #1;
        total++;
        if (lastRvalidCyc !== n + 3) begin
            bad++;
            $display("FAIL fetch_latency: rvalid cycle=%0d, required %0d", lastRvalidCyc, n + 3);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL fetch_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write;
        int r0;
        logic si, sd;
        r0 = rvalidCount;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_issue: req=%b we=%b addr=%h wdata=%h, required 1 1 00000100 deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_serve(0, 1, 32'h0, si, sd);
        dm_req = 0; dm_we = 0;
        total++;
        if (sd !== 1'b1 || si !== 1'b0) begin
            bad++;
            $display("FAIL write_gnt: dm_gnt=%b if_gnt=%b, required 1 0", sd, si);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL write_idle: busy=%b, required 0", busy);
        end
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (rvalidCount !== r0) begin
            bad++;
            $display("FAIL write_no_rvalid: rvalids=%0d, required %0d", rvalidCount - r0, 0);
        end
    endtask

    task automatic test_tie;
        logic expDm [3];
        logic [31:0] d;
        logic si, sd;
        int r0;
`ifdef SR_ARB_ROUND_ROBIN_EN
        expDm[0] = 1'b0; expDm[1] = 1'b1; expDm[2] = 1'b0;
`else
        expDm[0] = 1'b1; expDm[1] = 1'b1; expDm[2] = 1'b1;
`endif
        r0 = rvalidCount;
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            d = 32'hA0000000 + 32'(i);
            push_exp(expDm[i], d);
            mem_serve(0, 1, d, si, sd);
            total++;
            if (sd !== expDm[i] || si !== !expDm[i]) begin
                bad++;
                $display("FAIL tie_owner_%0d: dm_gnt=%b if_gnt=%b, required dm_gnt=%b", i, sd, si, expDm[i]);
            end
        end
        if_req = 0; dm_req = 0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || rvalidCount - r0 !== 3) begin
            bad++;
            $display("FAIL tie_done: busy=%b rvalids=%0d, required 0 3", busy, rvalidCount - r0);
        end
    endtask

    task automatic test_wait_states;
        int g0, r0;
        g0 = gntCount;
        r0 = rvalidCount;
        if_req = 1; if_addr = 32'h84;
        push_exp(1'b0, 32'hCAFEF00D);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h84 || if_gnt !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d: req=%b addr=%h gnt=%b, required 1 00000084 0", i, mem_req, mem_addr, if_gnt);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h84) begin
            bad++;
            $display("FAIL stall_accept: gnt=%b req=%b addr=%h, required 1 1 00000084", if_gnt, mem_req, mem_addr);
        end
        @(posedge clk); #1;
        mem_ready = 0;
        if_req = 0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_wait: busy=%b req=%b, required 1 0", busy, mem_req);
        end
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(posedge clk); #1;
        total++;
        if (gntCount - g0 !== 1 || rvalidCount - r0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_counts: gnts=%0d rvalids=%0d busy=%b, required 1 1 0",
                     gntCount - g0, rvalidCount - r0, busy);
        end
    endtask

    task automatic test_stray_rvalid;
        int r0;
        r0 = rvalidCount;
        total++;
        if (if_rdata !== lastIfData || dm_rdata !== lastDmData) begin
            bad++;
            $display("FAIL stray_before: if_rdata=%h dm_rdata=%h, required %h %h", if_rdata, dm_rdata, lastIfData, lastDmData);
        end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(posedge clk); #1;
        total++;
        if (rvalidCount !== r0 || if_rdata !== lastIfData || dm_rdata !== lastDmData || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_after: rvalids=%0d if_rdata=%h dm_rdata=%h busy=%b, required 0 %h %h 0",
                     rvalidCount - r0, if_rdata, dm_rdata, busy, lastIfData, lastDmData);
        end
    endtask

    task automatic test_reset_in_wait;
        int r0;
        r0 = rvalidCount;
        dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        @(posedge clk); #1;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        dm_req = 0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rstwait_busy: busy=%b, required 1", busy);
        end
        #2 rst = 1;
        #1;
        total++;
        if ({mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstwait_async: req=%b busy=%b addr=%h ifr=%h dmr=%h, required all 0",
                     mem_req, busy, mem_addr, if_rdata, dm_rdata);
        end
        @(posedge clk); #1;
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(posedge clk); #1;
        total++;
        if (rvalidCount !== r0 || busy !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstwait_late_rvalid: rvalids=%0d busy=%b req=%b dmr=%h ifr=%h, required 0 0 0 0 0",
                     rvalidCount - r0, busy, mem_req, dm_rdata, if_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_tie();
        test_wait_states();
        test_stray_rvalid();
        test_reset_in_wait();
        total++;
        if (expQ.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
